// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - shared time-field limits, widths and field-select encodings
package time_keeper_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int SM_W = 6;
  localparam int H_W  = 5;

  localparam logic [2:0] SEL_RUN  = 3'b000;
  localparam logic [2:0] SEL_SEC  = 3'b001;
  localparam logic [2:0] SEL_MIN  = 3'b010;
  localparam logic [2:0] SEL_HOUR = 3'b100;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  // Any nonzero select, including non-one-hot codes, freezes the clock.
  function automatic mode_e mode_of(input logic [2:0] sel);
    return (sel == SEL_RUN) ? MODE_RUN : MODE_SET;
  endfunction

endpackage

// File: rtl/time_keeper_wrap_counter.sv
// rtl/time_keeper_wrap_counter.sv - modulo (MAX+1) field counter with combinational carry-out
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc) begin
      q_d = (q_q == MAX_V) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = inc && (q_q == MAX_V);

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour real-time clock with field editing and long-press auto-repeat
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int REPEAT_HZ = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      set_time,
  input  logic            set_signal,
  input  logic            btn_long_signal,
  output logic [SM_W-1:0] t_s,
  output logic [SM_W-1:0] t_m,
  output logic [H_W-1:0]  t_h,
  output logic            tick_1hz,
  output logic            rollover
);

  localparam int REPEAT_DIV = CLK_HZ / REPEAT_HZ;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          set_signal_q;
  logic          tick_q, rollover_q;

  mode_e mode;
  logic  run, fire, set_rise, rep_hit, inc;
  logic  s_inc, m_inc, h_inc;
  logic  s_wrap, m_wrap, h_wrap;

  assign mode     = mode_of(set_time);
  assign run      = (mode == MODE_RUN);
  assign fire     = run && (presc_q == PRESC_LAST);
  assign set_rise = set_signal & ~set_signal_q;
  assign rep_hit  = btn_long_signal && (rep_q == REP_LAST);
  assign inc      = set_rise | rep_hit;

  // RUN chains carries upward; SET routes a single strobe to the selected field only.
  assign s_inc = run ? fire   : ((set_time == SEL_SEC)  && inc);
  assign m_inc = run ? s_wrap : ((set_time == SEL_MIN)  && inc);
  assign h_inc = run ? m_wrap : ((set_time == SEL_HOUR) && inc);

  always_comb begin
    presc_d = '0;
    if (run && !fire) begin
      presc_d = presc_q + 1'b1;
    end
    rep_d = '0;
    if (btn_long_signal && !rep_hit) begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      rep_q        <= '0;
      set_signal_q <= 1'b0;
      tick_q       <= 1'b0;
      rollover_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      rep_q        <= rep_d;
      set_signal_q <= set_signal;
      tick_q       <= fire;
      rollover_q   <= run && h_wrap;
    end
  end

  wrap_counter #(.MAX(SEC_MAX), .W(SM_W)) u_sec (
    .clk  (clk),
    .clr  (reset),
    .inc  (s_inc),
    .q    (t_s),
    .wrap (s_wrap)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(SM_W)) u_min (
    .clk  (clk),
    .clr  (reset),
    .inc  (m_inc),
    .q    (t_m),
    .wrap (m_wrap)
  );

  wrap_counter #(.MAX(HOUR_MAX), .W(H_W)) u_hour (
    .clk  (clk),
    .clr  (reset),
    .inc  (h_inc),
    .q    (t_h),
    .wrap (h_wrap)
  );

  assign tick_1hz = tick_q;
  assign rollover = rollover_q;

endmodule
